vga_scan_timing: RTL and testbench

- Pixel-scan timing generator and pixel output stage for the graphics pipeline.
- Drives the pixel coordinates, frame tick and sprite-refresh tick that the compositor consumes.
- Takes the compositor's RGB back, registers it and aligns it with delayed sync and data-enable.
- Blanks RGB outside the active area and drives the physical VGA pins.

---
 rtl/gfx_timing_pkg.sv | 28 ++
 rtl/vga_scan_timing_if.sv | 30 +++
 rtl/sync_delay_line.sv | 33 +++
 rtl/vga_scan_timing.sv | 148 ++++++++++++++
 tb/tb_vga_scan_timing.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_timing_pkg.sv
// gfx_timing_pkg
//   Shared definitions for the pixel-scan timing block:
//   - 800x600@60 timing constants and derived line/frame totals
//   - coordinate width used on the compositor bus
//   - rgb_t, one pixel as three 8-bit channels
package gfx_timing_pkg;

  localparam int COORD_W = 16;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/vga_scan_timing_if.sv
// vga_scan_timing_if
//   Compositor-side bus of the scan timing block.
//   o_x/o_y/o_frame  scan position and frame counter (timing -> compositor)
//   o_v_sync         one-cycle frame tick at the start of vertical blanking
//   o_refresh        one-cycle sprite-refresh tick
//   i_red/green/blue pixel colour returned by the compositor
//   Member names are seen from the timing generator (master) side.
interface vga_scan_timing_if;
  import gfx_timing_pkg::*;

  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic [COORD_W-1:0] o_frame;
  logic               o_v_sync;
  logic               o_refresh;
  logic [7:0]         i_red;
  logic [7:0]         i_green;
  logic [7:0]         i_blue;

  modport master (
    output o_x, o_y, o_frame, o_v_sync, o_refresh,
    input  i_red, i_green, i_blue
  );

  modport slave (
    input  o_x, o_y, o_frame, o_v_sync, o_refresh,
    output i_red, i_green, i_blue
  );

endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line
//   Strobe-enabled shift register with synchronous clear.
//   i_clk  clock            i_rst  synchronous active-high clear
//   i_en   shift enable     i_d    input word
//   o_q    word entered DEPTH enabled shifts earlier
module sync_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  // Shift chain; stage 0 takes the new word, higher stages age by one strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stage <= '0;
    end else if (i_en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_stage[0] <= i_d;
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing
//   Pixel-scan timing generator and VGA output stage.
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_pix_stb          pixel clock enable
//   bus (master)       scan position, frame tick, refresh tick, returned RGB
//   o_hsync, o_vsync   VGA syncs, active level SYNC_POL
//   o_de               data enable aligned with o_vga_*
//   o_vga_*            RGB forced to zero outside the active area
module vga_scan_timing
  import gfx_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = VGA_H_ACTIVE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_ACTIVE    = VGA_V_ACTIVE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   RGB_LAT     = 0,
  parameter int   REFRESH_DIV = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pix_stb,
  vga_scan_timing_if.master   bus,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_de,
  output logic [7:0]          o_vga_red,
  output logic [7:0]          o_vga_green,
  output logic [7:0]          o_vga_blue
);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_PRE    = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]         DIV_LAST = 8'(REFRESH_DIV - 1);

  logic [COORD_W-1:0] r_x, r_y, r_frame;
  logic               r_v_sync, r_refresh;
  logic [7:0]         r_div;
  rgb_t               r_rgb;

  logic w_x_last, w_y_last, w_vs_tick;
  logic w_de_raw, w_hs_raw, w_vs_raw;
  logic [2:0] w_dly;

  assign w_x_last  = (r_x == H_LAST);
  assign w_y_last  = (r_y == V_LAST);
  // Entering (0, V_ACTIVE) on this strobe marks the start of vertical blanking.
  assign w_vs_tick = i_pix_stb & w_x_last & (r_y == V_PRE);

  assign w_de_raw = (r_x < H_ACT) && (r_y < V_ACT);
  assign w_hs_raw = (r_x >= HS_START) && (r_x < HS_END);
  assign w_vs_raw = (r_y >= VS_START) && (r_y < VS_END);

  // Scan position and frame counter; line and frame wrap resolve in one update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
    end else if (i_pix_stb) begin
      if (w_x_last) begin
        r_x <= '0;
        if (w_y_last) begin
          r_y     <= '0;
          r_frame <= r_frame + 16'd1;
        end else begin
          r_y <= r_y + 16'd1;
        end
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  // Frame and refresh ticks are rewritten every clock so they stay one clock wide
  // even when strobes are sparse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v_sync  <= 1'b0;
      r_refresh <= 1'b0;
      r_div     <= 8'd0;
    end else begin
      r_v_sync  <= w_vs_tick;
      r_refresh <= w_vs_tick && (r_div == DIV_LAST);
      if (w_vs_tick) begin
        r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
      end
    end
  end

  // Compositor colour is sampled once per strobe; the delay line supplies the
  // remaining RGB_LAT stages for the timing flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb <= '0;
    end else if (i_pix_stb) begin
      r_rgb <= rgb_t'({bus.i_red, bus.i_green, bus.i_blue});
    end
  end

  sync_delay_line #(
    .DEPTH (RGB_LAT + 1),
    .WIDTH (3)
  ) u_sync_delay (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_pix_stb),
    .i_d   ({w_de_raw, w_hs_raw, w_vs_raw}),
    .o_q   (w_dly)
  );

  // Output stage: polarity on syncs, blanking on all colour channels.
  always_comb begin
    o_de        = w_dly[2];
    o_hsync     = w_dly[1] ? SYNC_POL : ~SYNC_POL;
    o_vsync     = w_dly[0] ? SYNC_POL : ~SYNC_POL;
    o_vga_red   = 8'h00;
    o_vga_green = 8'h00;
    o_vga_blue  = 8'h00;
    if (w_dly[2]) begin
      o_vga_red   = r_rgb.red;
      o_vga_green = r_rgb.green;
      o_vga_blue  = r_rgb.blue;
    end else begin
      o_vga_red   = 8'h00;
      o_vga_green = 8'h00;
      o_vga_blue  = 8'h00;
    end
  end

  assign bus.o_x       = r_x;
  assign bus.o_y       = r_y;
  assign bus.o_frame   = r_frame;
  assign bus.o_v_sync  = r_v_sync;
  assign bus.o_refresh = r_refresh;

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing
//   Directed bench on a reduced 15x10 raster (8/2/3/2 by 6/1/2/1).
//   dut0: RGB_LAT=0, SYNC_POL=1, REFRESH_DIV=2
//   dut1: RGB_LAT=0, SYNC_POL=1, REFRESH_DIV=1
//   dut2: RGB_LAT=2, SYNC_POL=0, REFRESH_DIV=2
module tb_vga_scan_timing;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stb = 1'b0;

  always #5 clk = ~clk;

  vga_scan_timing_if if0 ();
  vga_scan_timing_if if1 ();
  vga_scan_timing_if if2 ();

  logic hs0, vs0, de0, hs1, vs1, de1, hs2, vs2, de2;
  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;

  vga_scan_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .RGB_LAT(0), .REFRESH_DIV(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .bus(if0),
    .o_hsync(hs0), .o_vsync(vs0), .o_de(de0),
    .o_vga_red(r0), .o_vga_green(g0), .o_vga_blue(b0));

  vga_scan_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .RGB_LAT(0), .REFRESH_DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .bus(if1),
    .o_hsync(hs1), .o_vsync(vs1), .o_de(de1),
    .o_vga_red(r1), .o_vga_green(g1), .o_vga_blue(b1));

  vga_scan_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .RGB_LAT(2), .REFRESH_DIV(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .bus(if2),
    .o_hsync(hs2), .o_vsync(vs2), .o_de(de2),
    .o_vga_red(r2), .o_vga_green(g2), .o_vga_blue(b2));

  // Compositor models: zero latency for dut0/dut1, two-strobe latency for dut2.
  assign if0.i_red = if0.o_x[7:0];
  assign if0.i_green = if0.o_y[7:0];
  assign if0.i_blue = 8'hAA;
  assign if1.i_red = if1.o_x[7:0];
  assign if1.i_green = if1.o_y[7:0];
  assign if1.i_blue = 8'hAA;

  logic [1:0][23:0] comp_hist;
  always @(posedge clk) begin
    if (rst) comp_hist <= '0;
    else if (stb) comp_hist <= {comp_hist[0], {if2.o_x[7:0], if2.o_y[7:0], 8'hAA}};
  end
  assign if2.i_red = comp_hist[1][23:16];
  assign if2.i_green = comp_hist[1][15:8];
  assign if2.i_blue = comp_hist[1][7:0];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ex = 0, ey = 0, ef = 0, ticks = 0;
  int hx[3], hy[3];
  bit hv[3];
  bit exp_vs = 0, exp_ref = 0;

  function automatic bit de_of(int x, int y);
    return (x < HA) && (y < VA);
  endfunction
  function automatic bit hs_of(int x);
    return (x >= HA + HFP) && (x < HA + HFP + HS);
  endfunction
  function automatic bit vs_of(int y);
    return (y >= VA + VFP) && (y < VA + VFP + VS);
  endfunction
  function automatic logic [23:0] pix_of(int k);
    logic [7:0] xb, yb;
    xb = 8'(hx[k]);
    yb = 8'(hy[k]);
    if (hv[k] && de_of(hx[k], hy[k])) return {xb, yb, 8'hAA};
    return 24'h000000;
  endfunction

  task automatic step(input logic s, input logic r);
    stb = s;
    rst = r;
    @(posedge clk);
    if (r) begin
      ex = 0; ey = 0; ef = 0; ticks = 0; exp_vs = 0; exp_ref = 0;
      for (int k = 0; k < 3; k++) hv[k] = 1'b0;
    end else begin
      exp_vs = 0;
      exp_ref = 0;
      if (s) begin
        for (int k = 2; k > 0; k--) begin
          hx[k] = hx[k-1]; hy[k] = hy[k-1]; hv[k] = hv[k-1];
        end
        hx[0] = ex; hy[0] = ey; hv[0] = 1'b1;
        if (ex == HT - 1 && ey == VA - 1) begin
          exp_vs = 1; ticks++; exp_ref = (ticks % 2 == 0);
        end
        if (ex == HT - 1) begin
          ex = 0;
          if (ey == VT - 1) begin ey = 0; ef = (ef + 1) % 65536; end
          else ey++;
        end else ex++;
      end
    end
    #1;
    stb = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    checks++; if (if0.o_x !== 16'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", if0.o_x); end
    checks++; if (if0.o_y !== 16'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", if0.o_y); end
    checks++; if (if0.o_frame !== 16'd0) begin errors++; $display("FAIL reset_frame: got %0d want 0", if0.o_frame); end
    checks++; if (if0.o_v_sync !== 1'b0) begin errors++; $display("FAIL reset_vsync_tick: got %b want 0", if0.o_v_sync); end
    checks++; if (if0.o_refresh !== 1'b0) begin errors++; $display("FAIL reset_refresh: got %b want 0", if0.o_refresh); end
    checks++; if (de0 !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de0); end
    checks++; if ({r0, g0, b0} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {r0, g0, b0}); end
    checks++; if ({hs0, vs0} !== 2'b00) begin errors++; $display("FAIL reset_syncs_pol1: got %b want 00", {hs0, vs0}); end
    checks++; if ({hs2, vs2} !== 2'b11) begin errors++; $display("FAIL reset_syncs_pol0: got %b want 11", {hs2, vs2}); end
  endtask

  task automatic test_frame_scan();
    int nvs = 0, vsx = -1, vsy = -1;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b1, 1'b0);
      checks++; if (if0.o_x !== 16'(ex) || if0.o_y !== 16'(ey)) begin
        errors++; $display("FAIL scan_xy: got (%0d,%0d) want (%0d,%0d)", if0.o_x, if0.o_y, ex, ey);
      end
      checks++; if (if0.o_v_sync !== exp_vs) begin
        errors++; $display("FAIL scan_vtick: got %b want %b at (%0d,%0d)", if0.o_v_sync, exp_vs, ex, ey);
      end
      if (if0.o_v_sync === 1'b1) begin nvs++; vsx = int'(if0.o_x); vsy = int'(if0.o_y); end
    end
    checks++; if (if0.o_frame !== 16'd1) begin errors++; $display("FAIL scan_frame: got %0d want 1", if0.o_frame); end
    checks++; if (nvs != 1) begin errors++; $display("FAIL scan_vtick_count: got %0d want 1", nvs); end
    checks++; if (vsx != 0 || vsy != VA) begin errors++; $display("FAIL scan_vtick_pos: got (%0d,%0d) want (0,%0d)", vsx, vsy, VA); end
  endtask

  task automatic test_pixels();
    logic [23:0] e0, e2;
    for (int i = 0; i < HT * VT + 3; i++) begin
      step(1'b1, 1'b0);
      e0 = pix_of(0);
      e2 = pix_of(2);
      checks++; if (de0 !== (hv[0] && de_of(hx[0], hy[0]))) begin
        errors++; $display("FAIL lat0_de: got %b at src (%0d,%0d)", de0, hx[0], hy[0]);
      end
      checks++; if ({hs0, vs0} !== {hv[0] && hs_of(hx[0]), hv[0] && vs_of(hy[0])}) begin
        errors++; $display("FAIL lat0_syncs: got %b at src (%0d,%0d)", {hs0, vs0}, hx[0], hy[0]);
      end
      checks++; if ({r0, g0, b0} !== e0) begin
        errors++; $display("FAIL lat0_rgb: got %h want %h", {r0, g0, b0}, e0);
      end
      checks++; if (de2 !== (hv[2] && de_of(hx[2], hy[2]))) begin
        errors++; $display("FAIL lat2_de: got %b at src (%0d,%0d)", de2, hx[2], hy[2]);
      end
      checks++; if ({hs2, vs2} !== {!(hv[2] && hs_of(hx[2])), !(hv[2] && vs_of(hy[2]))}) begin
        errors++; $display("FAIL lat2_syncs: got %b at src (%0d,%0d)", {hs2, vs2}, hx[2], hy[2]);
      end
      checks++; if ({r2, g2, b2} !== e2) begin
        errors++; $display("FAIL lat2_rgb: got %h want %h", {r2, g2, b2}, e2);
      end
    end
  endtask

  task automatic test_refresh();
    int n = 0, mask = 0;
    step(1'b1, 1'b1);
    do begin
      step(1'b1, 1'b0);
      n++;
      checks++; if (if0.o_refresh !== exp_ref) begin
        errors++; $display("FAIL div2_refresh: got %b want %b tick %0d", if0.o_refresh, exp_ref, ticks);
      end
      checks++; if (if1.o_refresh !== exp_vs || if1.o_v_sync !== exp_vs) begin
        errors++; $display("FAIL div1_refresh: got %b/%b want %b", if1.o_refresh, if1.o_v_sync, exp_vs);
      end
      if (if0.o_refresh === 1'b1) mask |= (1 << ticks);
    end while (ticks < 6 && n < 8 * HT * VT);
    checks++; if (ticks < 6) begin errors++; $display("FAIL refresh_timeout: got %0d ticks want 6", ticks); end
    checks++; if (mask != 32'h54) begin errors++; $display("FAIL refresh_ticks: got mask %h want 54", mask); end
  endtask

  task automatic test_sparse_strobe();
    step(1'b1, 1'b1);
    for (int i = 0; i < 8 * HT * VT; i++) begin
      step((i % 4) == 0, 1'b0);
      checks++; if (if0.o_x !== 16'(ex) || if0.o_y !== 16'(ey)) begin
        errors++; $display("FAIL sparse_xy: got (%0d,%0d) want (%0d,%0d)", if0.o_x, if0.o_y, ex, ey);
      end
      checks++; if (if0.o_v_sync !== exp_vs || if0.o_refresh !== exp_ref) begin
        errors++; $display("FAIL sparse_ticks: got %b%b want %b%b", if0.o_v_sync, if0.o_refresh, exp_vs, exp_ref);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int n = 0, first = 0;
    while (!(ex == 11 && ey == 7) && n < 2 * HT * VT) begin step(1'b1, 1'b0); n++; end
    checks++; if ({hs0, vs0} !== 2'b11) begin errors++; $display("FAIL pre_reset_syncs: got %b want 11", {hs0, vs0}); end
    step(1'b0, 1'b1);
    checks++; if (if0.o_x !== 16'd0 || if0.o_y !== 16'd0) begin
      errors++; $display("FAIL mid_reset_xy: got (%0d,%0d) want (0,0)", if0.o_x, if0.o_y);
    end
    checks++; if (de0 !== 1'b0 || {r0, g0, b0} !== 24'h0) begin
      errors++; $display("FAIL mid_reset_out: got de %b rgb %h want 0", de0, {r0, g0, b0});
    end
    checks++; if ({hs0, vs0} !== 2'b00 || {hs2, vs2} !== 2'b11) begin
      errors++; $display("FAIL mid_reset_syncs: got %b/%b want 00/11", {hs0, vs0}, {hs2, vs2});
    end
    n = 0;
    while (ticks < 2 && n < 3 * HT * VT) begin
      step(1'b1, 1'b0);
      n++;
      checks++; if (if0.o_refresh !== exp_ref) begin
        errors++; $display("FAIL mid_reset_refresh: got %b want %b tick %0d", if0.o_refresh, exp_ref, ticks);
      end
      if (if0.o_refresh === 1'b1 && first == 0) first = ticks;
    end
    checks++; if (first != 2) begin errors++; $display("FAIL mid_reset_first_refresh: got tick %0d want 2", first); end
  endtask

  initial begin
    test_reset();
    test_frame_scan();
    test_pixels();
    test_refresh();
    test_sparse_strobe();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
